// File: rtl/t03_dpu_write_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : t03_dpu_pkg
// Description : DPU register map, status-word field layout and commit FSM states
// Revision    : 1.0 - initial release
// ============================================================================
package t03_dpu_pkg;

    localparam logic [31:0] STATUS_ADDR = 32'hFF00_0004;
    localparam logic [31:0] POS_ADDR    = 32'hFF00_0008;
    localparam logic [31:0] IDLE_ADDR   = 32'h0000_0000;

    localparam int GAME_STATE_LSB = 28;
    localparam int GAME_STATE_MSB = 30;
    localparam int P1_STATE_LSB   = 26;
    localparam int P1_STATE_MSB   = 27;
    localparam int P2_STATE_LSB   = 24;
    localparam int P2_STATE_MSB   = 25;
    localparam int P1_HEALTH_LSB  = 20;
    localparam int P1_HEALTH_MSB  = 23;
    localparam int P2_HEALTH_LSB  = 16;
    localparam int P2_HEALTH_MSB  = 19;
    localparam int P1_LEFT_BIT    = 1;
    localparam int P2_LEFT_BIT    = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_S = 2'd1,
        WR_P = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/t03_dpu_write_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : t03_dpu_write_sched_if
// Description : CPU write bus as seen by the DPU write scheduler
// Revision    : 1.0 - initial release
// ============================================================================
interface t03_dpu_write_sched_if;

    logic        cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ack;

    modport master (
        output cpu_wen,
        output cpu_addr,
        output cpu_wdata,
        input  cpu_ack
    );

    modport slave (
        input  cpu_wen,
        input  cpu_addr,
        input  cpu_wdata,
        output cpu_ack
    );

endinterface
`default_nettype wire

// File: rtl/t03_shadow_slot.sv
`default_nettype none
// ============================================================================
// Module      : t03_shadow_slot
// Description : One pending DPU word (data + valid) with overwrite detection
// Revision    : 1.0 - initial release
// ============================================================================
module t03_shadow_slot (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_wen,
    input  wire logic [31:0] i_wdata,
    input  wire logic        i_clr,
    output logic      [31:0] o_data,
    output logic             o_vld,
    output logic             o_ovw
);

    logic [31:0] r_data;
    logic        r_vld;

    // A write landing on the clearing edge starts a fresh pending word
    assign o_ovw  = i_wen & r_vld & ~i_clr;
    assign o_data = r_data;
    assign o_vld  = r_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_vld  <= 1'b0;
        end else begin
            if (i_wen) begin
                r_data <= i_wdata;
            end
            if (i_wen) begin
                r_vld <= 1'b1;
            end else if (i_clr) begin
                r_vld <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/t03_dpu_write_sched.sv
`default_nettype none
// ============================================================================
// Module      : t03_dpu_write_sched
// Description : Shadows CPU status/position writes and replays them to the DPU
//               on the vsync rising edge so frames never tear
// Revision    : 1.0 - initial release
// ============================================================================
module t03_dpu_write_sched #(
    parameter logic [31:0] STATUS_ADDR = t03_dpu_pkg::STATUS_ADDR,
    parameter logic [31:0] POS_ADDR    = t03_dpu_pkg::POS_ADDR,
    parameter logic [31:0] IDLE_ADDR   = t03_dpu_pkg::IDLE_ADDR
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    t03_dpu_write_sched_if.slave       bus,
    input  wire logic                  vsync,
    output logic      [31:0]           dpu_addr,
    output logic      [31:0]           dpu_data,
    output logic                       busy,
    output logic      [15:0]           frame_cnt,
    output logic      [7:0]            ovw_cnt
);

    import t03_dpu_pkg::*;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_vsync_q;
    logic        r_ack;
    logic        r_busy;
    logic        r_snap_has_p;
    logic [31:0] r_snap_p;
    logic [31:0] r_dpu_addr;
    logic [31:0] r_dpu_data;
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_ovw_cnt;

    logic        w_vs_edge;
    logic        w_commit;
    logic        w_wen_s;
    logic        w_wen_p;
    logic [31:0] w_pend_s;
    logic [31:0] w_pend_p;
    logic        w_vld_s;
    logic        w_vld_p;
    logic        w_ovw_s;
    logic        w_ovw_p;
    logic [31:0] w_addr_nxt;
    logic [31:0] w_data_nxt;

    assign w_vs_edge = vsync & ~r_vsync_q;
    assign w_commit  = (r_state == IDLE) & w_vs_edge & (w_vld_s | w_vld_p);
    assign w_wen_s   = bus.cpu_wen & (bus.cpu_addr == STATUS_ADDR);
    assign w_wen_p   = bus.cpu_wen & (bus.cpu_addr == POS_ADDR);

    t03_shadow_slot u_slot_s (
        .clk     (clk),
        .rst     (rst),
        .i_wen   (w_wen_s),
        .i_wdata (bus.cpu_wdata),
        .i_clr   (w_commit),
        .o_data  (w_pend_s),
        .o_vld   (w_vld_s),
        .o_ovw   (w_ovw_s)
    );

    t03_shadow_slot u_slot_p (
        .clk     (clk),
        .rst     (rst),
        .i_wen   (w_wen_p),
        .i_wdata (bus.cpu_wdata),
        .i_clr   (w_commit),
        .o_data  (w_pend_p),
        .o_vld   (w_vld_p),
        .o_ovw   (w_ovw_p)
    );

    // The status snapshot goes straight into the output register since it is
    // always the first word; only the position word needs a holding register.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = IDLE_ADDR;
        w_data_nxt  = '0;
        case (r_state)
            IDLE: begin
                if (w_commit) begin
                    if (w_vld_s) begin
                        w_state_nxt = WR_S;
                        w_addr_nxt  = STATUS_ADDR;
                        w_data_nxt  = w_pend_s;
                    end else begin
                        w_state_nxt = WR_P;
                        w_addr_nxt  = POS_ADDR;
                        w_data_nxt  = w_pend_p;
                    end
                end
            end
            WR_S: begin
                if (r_snap_has_p) begin
                    w_state_nxt = WR_P;
                    w_addr_nxt  = POS_ADDR;
                    w_data_nxt  = r_snap_p;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WR_P: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_vsync_q    <= 1'b0;
            r_ack        <= 1'b0;
            r_busy       <= 1'b0;
            r_snap_has_p <= 1'b0;
            r_snap_p     <= '0;
            r_dpu_addr   <= IDLE_ADDR;
            r_dpu_data   <= '0;
            r_frame_cnt  <= '0;
            r_ovw_cnt    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_vsync_q  <= vsync;
            r_ack      <= bus.cpu_wen;
            r_busy     <= (w_state_nxt != IDLE);
            r_dpu_addr <= w_addr_nxt;
            r_dpu_data <= w_data_nxt;
            if (w_commit) begin
                r_snap_has_p <= w_vld_p;
                r_snap_p     <= w_pend_p;
            end
            if ((r_state != IDLE) && (w_state_nxt == IDLE)) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if ((w_ovw_s | w_ovw_p) && (r_ovw_cnt != 8'hFF)) begin
                r_ovw_cnt <= r_ovw_cnt + 8'd1;
            end
        end
    end

    assign bus.cpu_ack = r_ack;
    assign dpu_addr    = r_dpu_addr;
    assign dpu_data    = r_dpu_data;
    assign busy        = r_busy;
    assign frame_cnt   = r_frame_cnt;
    assign ovw_cnt     = r_ovw_cnt;

endmodule
`default_nettype wire

// File: tb/tb_t03_dpu_write_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_t03_dpu_write_sched
// Description : Scoreboard bench for t03_dpu_write_sched with a frame-level model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_t03_dpu_write_sched;

    import t03_dpu_pkg::*;

    logic        clk;
    logic        rst;
    logic        vsync;
    logic [31:0] dpu_addr;
    logic [31:0] dpu_data;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [7:0]  ovw_cnt;

    t03_dpu_write_sched_if bus ();

    t03_dpu_write_sched dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .vsync     (vsync),
        .dpu_addr  (dpu_addr),
        .dpu_data  (dpu_data),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .ovw_cnt   (ovw_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } word_t;

    word_t       exp_q[$];
    int          cyc;
    int          n_vec;
    int          n_err;

    // Reference model: what the CPU has asked for, and when the next frame may start
    logic [31:0] m_pend_s;
    logic [31:0] m_pend_p;
    bit          m_has_s;
    bit          m_has_p;
    bit          m_vs_prev;
    int          m_free_at;
    int          m_frame_at;
    logic [15:0] m_frames;
    int          m_ovw;
    bit          m_ack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_pend_s   = '0;
        m_pend_p   = '0;
        m_has_s    = 0;
        m_has_p    = 0;
        m_vs_prev  = 0;
        m_free_at  = 0;
        m_frame_at = -1;
        m_frames   = '0;
        m_ovw      = 0;
        m_ack      = 0;
    endtask

    task automatic tick();
        bit edge_seen;
        bit commit;
        int n;
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_clear();
        end else begin
            m_ack = bus.cpu_wen;
            if (cyc == m_frame_at) m_frames++;
            edge_seen = vsync && !m_vs_prev;
            m_vs_prev = vsync;
            commit    = edge_seen && (cyc >= m_free_at) && (m_has_s || m_has_p);
            if (commit) begin
                n = 0;
                if (m_has_s) begin
                    exp_q.push_back('{cyc + n, STATUS_ADDR, m_pend_s});
                    n++;
                end
                if (m_has_p) begin
                    exp_q.push_back('{cyc + n, POS_ADDR, m_pend_p});
                    n++;
                end
                m_frame_at = cyc + n;
                m_free_at  = cyc + n + 1;
                m_has_s    = 0;
                m_has_p    = 0;
            end
            if (bus.cpu_wen && bus.cpu_addr == STATUS_ADDR) begin
                if (m_has_s && m_ovw < 255) m_ovw++;
                m_pend_s = bus.cpu_wdata;
                m_has_s  = 1;
            end else if (bus.cpu_wen && bus.cpu_addr == POS_ADDR) begin
                if (m_has_p && m_ovw < 255) m_ovw++;
                m_pend_p = bus.cpu_wdata;
                m_has_p  = 1;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.cpu_wen   = 1'b1;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = data;
        tick();
        bus.cpu_wen   = 1'b0;
    endtask

    task automatic vs_pulse();
        vsync = 1'b1;
        idle(2);
        vsync = 1'b0;
        idle(3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        #1;
        chk("rst_dpu_addr", dpu_addr, IDLE_ADDR);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        tick();
        rst = 1'b0;
    endtask

    // Monitor: a scheduled DPU word must appear exactly in its cycle, otherwise the port is inert
    always @(negedge clk) begin
        word_t w;
        if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            w = exp_q.pop_front();
            chk("dpu_addr", dpu_addr, w.addr);
            chk("dpu_data", dpu_data, w.data);
            chk("busy_word", {31'd0, busy}, 32'd1);
        end else begin
            chk("dpu_addr_idle", dpu_addr, IDLE_ADDR);
            chk("dpu_data_idle", dpu_data, 32'd0);
            chk("busy_idle", {31'd0, busy}, 32'd0);
        end
        chk("cpu_ack", {31'd0, bus.cpu_ack}, {31'd0, m_ack});
        chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_frames});
        chk("ovw_cnt", {24'd0, ovw_cnt}, m_ovw);
    end

    function automatic logic [31:0] rand_status();
        logic [31:0] v;
        v = '0;
        v[GAME_STATE_MSB:GAME_STATE_LSB] = 3'($urandom_range(0, 7));
        v[P1_STATE_MSB:P1_STATE_LSB]     = 2'($urandom_range(0, 3));
        v[P2_STATE_MSB:P2_STATE_LSB]     = 2'($urandom_range(0, 3));
        v[P1_HEALTH_MSB:P1_HEALTH_LSB]   = 4'($urandom_range(0, 15));
        v[P2_HEALTH_MSB:P2_HEALTH_LSB]   = 4'($urandom_range(0, 15));
        v[P1_LEFT_BIT]                   = 1'($urandom_range(0, 1));
        v[P2_LEFT_BIT]                   = 1'($urandom_range(0, 1));
        return v;
    endfunction

    initial begin
        cyc   = 0;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        vsync = 1'b0;
        bus.cpu_wen   = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        model_clear();
        idle(2);
        rst = 1'b0;
        idle(2);

        // Single status word
        wr(STATUS_ADDR, 32'h5A34_0003);
        vs_pulse();
        chk("frame_after_one", {16'd0, frame_cnt}, 32'd1);

        // Status then position
        do_reset();
        wr(POS_ADDR, 32'h1020_3040);
        wr(STATUS_ADDR, 32'h1230_0000);
        vs_pulse();
        chk("frame_after_two", {16'd0, frame_cnt}, 32'd1);

        // Overwrites and saturation
        do_reset();
        wr(POS_ADDR, 32'h0000_0001);
        wr(POS_ADDR, 32'h0000_0002);
        wr(POS_ADDR, 32'h0000_0003);
        chk("ovw_two", {24'd0, ovw_cnt}, 32'd2);
        vs_pulse();
        for (int i = 0; i < 300; i++) wr(POS_ADDR, i);
        chk("ovw_sat", {24'd0, ovw_cnt}, 32'd255);
        vs_pulse();

        // Write coinciding with the snapshot edge
        do_reset();
        wr(STATUS_ADDR, 32'h1111_1111);
        bus.cpu_wen   = 1'b1;
        bus.cpu_addr  = STATUS_ADDR;
        bus.cpu_wdata = 32'hAAAA_0000;
        vsync         = 1'b1;
        tick();
        bus.cpu_wen   = 1'b0;
        idle(1);
        vsync = 1'b0;
        idle(3);
        vs_pulse();
        chk("ovw_same_edge", {24'd0, ovw_cnt}, 32'd0);
        chk("frame_same_edge", {16'd0, frame_cnt}, 32'd2);

        // Empty vsync and foreign address
        vs_pulse();
        wr(32'h1234_5678, 32'hDEAD_BEEF);
        vs_pulse();
        chk("frame_empty", {16'd0, frame_cnt}, 32'd2);

        // Reset while the status word is on the port
        wr(STATUS_ADDR, 32'hCAFE_0001);
        wr(POS_ADDR, 32'hCAFE_0002);
        vsync = 1'b1;
        tick();
        chk("pre_rst_addr", dpu_addr, STATUS_ADDR);
        do_reset();
        idle(1);
        vsync = 1'b0;
        idle(2);
        vs_pulse();

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) vsync = ~vsync;
            if ($urandom_range(0, 9) < 4) begin
                bus.cpu_wen = 1'b1;
                case ($urandom_range(0, 4))
                    0, 1: begin
                        bus.cpu_addr  = STATUS_ADDR;
                        bus.cpu_wdata = rand_status();
                    end
                    2, 3: begin
                        bus.cpu_addr  = POS_ADDR;
                        bus.cpu_wdata = $urandom();
                    end
                    default: begin
                        bus.cpu_addr  = $urandom();
                        bus.cpu_wdata = $urandom();
                    end
                endcase
            end else begin
                bus.cpu_wen = 1'b0;
            end
            if ($urandom_range(0, 999) == 0) begin
                bus.cpu_wen = 1'b0;
                do_reset();
            end else begin
                tick();
            end
        end
        bus.cpu_wen = 1'b0;
        vsync = 1'b0;
        idle(6);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
